// File: rtl/segdisp_pkg.sv
// Shared constants for the game-board seven-segment display: digit count,
// active-low glyph codes and FSM state encodings.
package segdisp_pkg;

  localparam int N_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [1:0] CONV_IDLE  = 2'd0;
  localparam logic [1:0] CONV_SHIFT = 2'd1;
  localparam logic [1:0] CONV_DONE  = 2'd2;

  localparam logic OWN_SCORE = 1'b0;
  localparam logic OWN_MSG   = 1'b1;

  // Nibbles 10..15 never come out of a valid conversion; show them blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_display_sched_bin2bcd_seq.sv
// Serial shift/add-3 binary-to-BCD converter, one bit per clock, with a
// one-deep pending slot so scores arriving mid-conversion are not lost.
module bin2bcd_seq
  import segdisp_pkg::*;
#(
  parameter int SCORE_MAX = 9999
) (
  input  logic        segclk,
  input  logic        clr,
  input  logic [14:0] score,
  input  logic        score_vld,
  output logic        busy,
  output logic [15:0] bcd_out
);

  logic [1:0]  state;
  logic [3:0]  bitcnt;
  logic [14:0] bin_sr;
  logic [15:0] bcd_sr;
  logic [15:0] bcd_adj;
  logic        pend_vld;
  logic [14:0] pend_val;
  logic [14:0] sat_score;

  assign sat_score = (score > 15'(SCORE_MAX)) ? 15'(SCORE_MAX) : score;
  assign busy      = (state != CONV_IDLE);

  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  // bcd_out only changes in DONE, so the display never sees a partial result.
  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      state    <= CONV_IDLE;
      bitcnt   <= '0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      bcd_out  <= '0;
      pend_vld <= 1'b0;
      pend_val <= '0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (score_vld) begin
            bin_sr <= sat_score;
            bcd_sr <= '0;
            bitcnt <= '0;
            state  <= CONV_SHIFT;
          end else if (pend_vld) begin
            bin_sr   <= pend_val;
            bcd_sr   <= '0;
            bitcnt   <= '0;
            pend_vld <= 1'b0;
            state    <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          bcd_sr <= {bcd_adj[14:0], bin_sr[14]};
          bin_sr <= {bin_sr[13:0], 1'b0};
          bitcnt <= bitcnt + 4'd1;
          if (bitcnt == 4'd14) state <= CONV_DONE;
          if (score_vld) begin
            pend_vld <= 1'b1;
            pend_val <= sat_score;
          end
        end
        CONV_DONE: begin
          bcd_out <= bcd_sr;
          if (pend_vld) begin
            bin_sr <= pend_val;
            bcd_sr <= '0;
            bitcnt <= '0;
            state  <= CONV_SHIFT;
          end else begin
            state <= CONV_IDLE;
          end
          pend_vld <= score_vld;
          if (score_vld) pend_val <= sat_score;
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_display_sched.sv
// Four-digit display sequencer: anode scan, score/message ownership and segment mux.
// Define LZ_BLANK_EN to blank leading zeros of the score (digit0 always shown).
module score_display_sched
  import segdisp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int MSG_FRAMES  = 200,
  parameter int SCORE_MAX   = 9999
) (
  input  logic        segclk,
  input  logic        clr,
  input  logic [14:0] score,
  input  logic        score_vld,
  input  logic        msg_req,
  input  logic [27:0] msg_pat,
  output logic        msg_ack,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(MSG_FRAMES + 1);

  logic [RW-1:0] refcnt;
  logic [1:0]    idx;
  logic          live;
  logic          own;
  logic [FW-1:0] frames;
  logic [15:0]   disp;
  logic          refresh_tc;
  logic          frame_wrap;
  logic [15:0]   disp_shift;
  logic [6:0]    msg_glyph;
  logic          lead_zero;

  bin2bcd_seq #(.SCORE_MAX(SCORE_MAX)) u_conv (
    .segclk    (segclk),
    .clr       (clr),
    .score     (score),
    .score_vld (score_vld),
    .busy      (busy),
    .bcd_out   (disp)
  );

  assign refresh_tc = (refcnt == RW'(REFRESH_DIV - 1));
  assign frame_wrap = refresh_tc && (idx == 2'd3);

  // Ownership only changes on a frame wrap so a glyph set is never torn mid-frame.
  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      refcnt  <= '0;
      idx     <= '0;
      live    <= 1'b0;
      own     <= OWN_SCORE;
      frames  <= '0;
      msg_ack <= 1'b0;
    end else begin
      live    <= 1'b1;
      msg_ack <= 1'b0;
      if (refresh_tc) begin
        refcnt <= '0;
        idx    <= idx + 2'd1;
      end else begin
        refcnt <= refcnt + RW'(1);
      end
      if (frame_wrap) begin
        if (own == OWN_MSG) begin
          if (frames == FW'(MSG_FRAMES - 1)) begin
            own     <= OWN_SCORE;
            msg_ack <= 1'b1;
            frames  <= '0;
          end else begin
            frames <= frames + FW'(1);
          end
        end else if (msg_req) begin
          own    <= OWN_MSG;
          frames <= '0;
        end
      end
    end
  end

  always_comb begin
    disp_shift = disp >> {idx, 2'b00};
    case (idx)
      2'd0:    msg_glyph = msg_pat[6:0];
      2'd1:    msg_glyph = msg_pat[13:7];
      2'd2:    msg_glyph = msg_pat[20:14];
      default: msg_glyph = msg_pat[27:21];
    endcase
`ifdef LZ_BLANK_EN
    lead_zero = (idx != 2'd0) && (disp_shift == 16'd0);
`else
    lead_zero = 1'b0;
`endif
    if (!live)                seg = SEG_BLANK;
    else if (own == OWN_MSG)  seg = msg_glyph;
    else if (lead_zero)       seg = SEG_BLANK;
    else                      seg = seg_decode(disp_shift[3:0]);
    an = live ? ~(4'b0001 << idx) : 4'hF;
  end

endmodule

// File: tb/tb_score_display_sched.sv
// Self-checking bench for score_display_sched: directed scenarios plus random
// scores and message requests against a cycle-count based reference model.
module tb_score_display_sched;

  localparam int R  = 4;
  localparam int MF = 2;
  localparam int FRAME = 4 * R;

  logic        segclk = 1'b0;
  logic        clr;
  logic [14:0] score;
  logic        score_vld;
  logic        msg_req;
  logic [27:0] msg_pat;
  logic        msg_ack;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  // reference model state: k = clock edges since reset release
  int k;
  int busy_end;
  bit pend_v;
  int pend_val;
  int disp_val;
  int disp_at;
  int disp_next;
  bit msg_mode;
  int frames_left;
  bit ack_exp;
  bit req_level;

  always #5 segclk = ~segclk;

  score_display_sched #(.REFRESH_DIV(R), .MSG_FRAMES(MF), .SCORE_MAX(9999)) dut (
    .segclk    (segclk),
    .clr       (clr),
    .score     (score),
    .score_vld (score_vld),
    .msg_req   (msg_req),
    .msg_pat   (msg_pat),
    .msg_ack   (msg_ack),
    .busy      (busy),
    .seg       (seg),
    .an        (an)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [6:0] exp_seg();
    int i;
    logic [27:0] pat;
    if (k == 0) return 7'h7F;
    i = (k / R) % 4;
    pat = msg_pat;
    if (msg_mode) return pat[7*i +: 7];
`ifdef LZ_BLANK_EN
    if (i > 0 && disp_val < pow10(i)) return 7'h7F;
`endif
    return glyph((disp_val / pow10(i)) % 10);
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one = 4'b0001;
    if (k == 0) return 4'hF;
    return ~(one << ((k / R) % 4));
  endfunction

  task automatic model_reset();
    k = 0; busy_end = -1; pend_v = 0; pend_val = 0;
    disp_val = 0; disp_at = -1; disp_next = 0;
    msg_mode = 0; frames_left = 0; ack_exp = 0;
  endtask

  task automatic model_edge(input bit vld, input int val, input bit req);
    int old_end;
    k++;
    ack_exp = 0;
    if (k == disp_at) disp_val = disp_next;
    old_end = busy_end;
    if (k == busy_end && pend_v) begin
      busy_end = k + 16; disp_at = k + 16; disp_next = pend_val; pend_v = 0;
    end
    if (vld) begin
      if (k > old_end) begin
        busy_end = k + 16; disp_at = k + 16; disp_next = sat(val);
      end else begin
        pend_v = 1; pend_val = sat(val);
      end
    end
    if (k % FRAME == 0) begin
      if (msg_mode) begin
        frames_left--;
        if (frames_left == 0) begin msg_mode = 0; ack_exp = 1; end
      end else if (req) begin
        msg_mode = 1; frames_left = MF;
      end
    end
  endtask

  task automatic check_cycle();
    checkOutput("an", {28'd0, an}, {28'd0, exp_an()});
    checkOutput("seg", {25'd0, seg}, {25'd0, exp_seg()});
    checkOutput("busy", {31'd0, busy}, {31'd0, (k < busy_end)});
    checkOutput("msg_ack", {31'd0, msg_ack}, {31'd0, ack_exp});
  endtask

  // called at a negedge; drives one cycle, advances the model, checks outputs
  task automatic applyStimulus(input bit vld, input logic [14:0] val);
    score_vld = vld;
    score     = val;
    msg_req   = req_level;
    @(posedge segclk);
    model_edge(vld, int'(val), req_level);
    @(negedge segclk);
    score_vld = 1'b0;
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 15'd0);
  endtask

  // keep strobes off the DONE cycle, where pending behaviour is not pinned down
  task automatic issue(input logic [14:0] val);
    if (k + 1 == busy_end) run(1);
    applyStimulus(1'b1, val);
  endtask

  task automatic do_reset();
    #2;
    clr = 1'b1; score_vld = 1'b0; req_level = 1'b0; msg_req = 1'b0;
    #1;
    checkOutput("rst_seg", {25'd0, seg}, 32'h7F);
    checkOutput("rst_an", {28'd0, an}, 32'hF);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ack", {31'd0, msg_ack}, 32'd0);
    @(negedge segclk);
    @(negedge segclk);
    clr = 1'b0;
    model_reset();
    check_cycle();
  endtask

  initial begin
    bit seen;
    clr = 1'b1; score = '0; score_vld = 1'b0; msg_req = 1'b0; req_level = 1'b0;
    msg_pat = {7'h08, 7'h40, 7'h40, 7'h42};
    model_reset();
    @(negedge segclk);
    do_reset();

    // clr in the middle of a conversion
    issue(15'd2345);
    run(7);
    do_reset();
    run(24);

    // full conversion and scan
    issue(15'd2345);
    run(40);

    // saturation and zero
    issue(15'd12000);
    run(36);
    issue(15'd0);
    run(36);

    // last pending write wins
    issue(15'd100);
    run(2);
    issue(15'd200);
    run(2);
    issue(15'd300);
    run(50);

    // message display, requested mid-frame
    run(5);
    msg_pat = {7'h08, 7'h40, 7'h40, 7'h42};
    req_level = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      run(1);
      if (ack_exp) seen = 1'b1;
    end
    checkOutput("msg_ack_seen", {31'd0, seen}, 32'd1);
    req_level = 1'b0;
    run(20);

    // leading-zero handling
    issue(15'd7);
    run(40);

    // random scores and message requests
    for (int i = 0; i < 600; i++) begin
      bit vld;
      if (!msg_mode && !req_level && ($urandom % 25 == 0)) begin
        msg_pat   = 28'($urandom);
        req_level = 1'b1;
      end
      vld = ($urandom % 6 == 0) && (k + 1 != busy_end);
      applyStimulus(vld, 15'($urandom_range(0, 32767)));
      if (ack_exp) req_level = ($urandom % 3 == 0);
    end
    req_level = 1'b0;
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
